router_dst_sync: RTL and testbench
==================================

# router_dst_sync

Synchronizer and read-side watchdog between the router's packet FSM, its three destination FIFOs and the three destination read ports. It latches the header address, steers FIFO write enables and the full status, drives `vld_out` toward each destination and, per destination, times out a packet that sits unread. On timeout it issues a soft reset so the affected FIFO is flushed and cannot block the router.

## Interface
Parameters:
- `NUM_DST`, 3, number of destination ports/FIFOs
- `ADDR_W`, 2, width of header address field
- `TIMEOUT`, 30, consecutive unread-valid cycles before soft reset (≥2)

Ports:
- `clock`  in  1  single clock, all state on posedge
- `resetn`  in  1  asynchronous, active-low reset
- `detect_add`  in  1  FSM strobe: header byte present on `data_in`
- `data_in`  in  `ADDR_W`  destination address bits of header
- `write_enb_reg`  in  1  FSM request to write current byte into selected FIFO
- `read_enb`  in  `NUM_DST`  `rd_enb` from each destination
- `empty`  in  `NUM_DST`  FIFO empty flags
- `full`  in  `NUM_DST`  FIFO full flags
- `write_enb`  out  `NUM_DST`  one-hot FIFO write enable
- `fifo_full`  out  1  full flag of the selected FIFO
- `vld_out`  out  `NUM_DST`  data valid toward each destination
- `soft_reset`  out  `NUM_DST`  one-cycle FIFO flush pulse per destination
- `addr_err`  out  1  latched address ≥ `NUM_DST`

## Operation
- Address register `addr`: loads `data_in` at each posedge with `detect_add`=1; holds otherwise.
- `write_enb[i]` = `write_enb_reg` && (`addr`==i). Invalid address: all zero.
- `fifo_full` = `full[addr]`; 0 for an invalid address.
- `addr_err` = (`addr` ≥ `NUM_DST`).
- `vld_out[i]` = !`empty[i]`.
- Per-port timer `cnt[i]`, width $clog2(`TIMEOUT`):
  - `vld_out[i]` && !`read_enb[i]`: if `cnt[i]`==`TIMEOUT`-1, set `soft_reset[i]`=1 and `cnt[i]`=0; else increment.
  - Otherwise (read or empty): `cnt[i]`=0.
  - `soft_reset[i]` is high only in the cycle after the terminal count. It self-clears.
- Ports are fully independent. Several `soft_reset` bits may pulse in the same cycle.

## Timing
- Reset values:
  - `addr`=0, all `cnt`=0, `soft_reset`=0, `addr_err`=0.
  - `write_enb`, `fifo_full` and `vld_out` follow their combinational equations from the reset state.
- `write_enb`, `fifo_full`, `vld_out` and `addr_err` are combinational, so a new `addr` affects them in the cycle after the `detect_add` edge.
- `detect_add` and `write_enb_reg` in the same cycle: `write_enb` uses the old `addr`.
- `soft_reset[i]` rises exactly `TIMEOUT` cycles after the first cycle of an unbroken vld&&!rd run. With `TIMEOUT`=30 and the run starting in cycle 0, it is high in cycle 30.
- `read_enb[i]` in the terminal-count cycle: no pulse, counter clears.
- `empty[i]` rising in the terminal-count cycle: no pulse, counter clears.
- Run continues after a pulse: counting restarts from 0. The next pulse comes `TIMEOUT` cycles later, unless the flush empties the FIFO first.
- `resetn` low mid-count: counters and pulses clear immediately (asynchronously). The timer counts again starting from the first posedge after release.

## Configuration
- `ROUTER_DST_TIMEOUT_EN` defined: per-port timers and `soft_reset` are implemented as specified.
- `ROUTER_DST_TIMEOUT_EN` undefined:
  - No timers are instantiated and `soft_reset` is tied to 0.
  - All other behaviour is unchanged.

## Structure
- Shared package `router_pkg` holds:
  - `NUM_DST`, `ADDR_W` and the default `TIMEOUT`
  - typedef `dst_addr_t` (logic [`ADDR_W`-1:0])
  - `ADDR_INVALID` = 2'b11
- Sub-module `router_dst_timer`: one counter plus pulse register, instantiated `NUM_DST` times in a generate loop. The whole generate is guarded by `ROUTER_DST_TIMEOUT_EN`.

## Test plan
- Reset check: reset asserted, then `detect_add`=1 with `data_in`=2'b01, then `write_enb_reg`=1 → `write_enb`=3'b010 from the next cycle; `fifo_full` mirrors `full[1]`.
- Invalid address: `data_in`=2'b11 latched, `write_enb_reg`=1 → `write_enb`=3'b000, `fifo_full`=0, `addr_err`=1.
- Timeout:
  - Stimulus: `empty[0]`=0 and `read_enb[0]`=0 for 30 cycles.
  - Response: `soft_reset[0]`=1 in cycle 30 only. Other bits stay 0.
- Timeout abort:
  - Stimulus: as above, but `read_enb[0]`=1 in cycle 29.
  - Response: no pulse; the counter restarts when the run resumes, so the pulse moves to 30 cycles after the restart.
- Simultaneous ports: `empty`=3'b000 and `read_enb`=0 for 30 cycles → `soft_reset`=3'b111 in one cycle.
- Reset mid-operation: `resetn` low at count 20, then released → no pulse until 30 fresh cycles have elapsed. With the macro undefined, `soft_reset` stays 0 throughout.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and types: destination count, header address width,
// default watchdog timeout and the reserved invalid address code.
package router_pkg;

  localparam int unsigned NUM_DST     = 3;
  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned TIMEOUT_DEF = 30;

  typedef logic [ADDR_W-1:0] dst_addr_t;

  localparam dst_addr_t ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_dst_timer.sv
// Per-destination read watchdog: counts consecutive valid-but-unread cycles and
// emits a one-cycle soft_reset pulse in the cycle after the terminal count.
module router_dst_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_vld,
  input  logic i_rd,
  output logic o_soft_reset
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;
  logic             w_stall;
  logic             w_term;

  assign w_stall = i_vld && !i_rd;
  assign w_term  = w_stall && (r_cnt == CNT_W'(TIMEOUT - 1));

  // A read, an empty FIFO or the terminal count all restart the run
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= w_term;
      if (w_stall && !w_term) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_dst_sync.sv
// Router destination synchronizer: latches the header address, steers FIFO write
// enables and full status, drives vld_out, and (with ROUTER_DST_TIMEOUT_EN)
// flushes any destination FIFO left unread for TIMEOUT cycles.
module router_dst_sync #(
  parameter int unsigned NUM_DST = router_pkg::NUM_DST,
  parameter int unsigned ADDR_W  = router_pkg::ADDR_W,
  parameter int unsigned TIMEOUT = router_pkg::TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               detect_add,
  input  logic [ADDR_W-1:0]  data_in,
  input  logic               write_enb_reg,
  input  logic [NUM_DST-1:0] read_enb,
  input  logic [NUM_DST-1:0] empty,
  input  logic [NUM_DST-1:0] full,
  output logic [NUM_DST-1:0] write_enb,
  output logic               fifo_full,
  output logic [NUM_DST-1:0] vld_out,
  output logic [NUM_DST-1:0] soft_reset,
  output logic               addr_err
);

  logic [ADDR_W-1:0]  r_addr;
  logic [NUM_DST-1:0] w_sel;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
    end else if (detect_add) begin
      r_addr <= data_in;
    end
  end

  // One-hot destination select; an out-of-range address selects nothing
  for (genvar i = 0; i < NUM_DST; i++) begin : g_sel
    assign w_sel[i] = (32'(r_addr) == 32'(i));
  end

  assign write_enb = w_sel & {NUM_DST{write_enb_reg}};
  assign fifo_full = |(full & w_sel);
  assign addr_err  = (32'(r_addr) >= NUM_DST);
  assign vld_out   = ~empty;

`ifdef ROUTER_DST_TIMEOUT_EN
  for (genvar i = 0; i < NUM_DST; i++) begin : g_timer
    router_dst_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clock        (clock),
      .resetn       (resetn),
      .i_vld        (vld_out[i]),
      .i_rd         (read_enb[i]),
      .o_soft_reset (soft_reset[i])
    );
  end
`else
  logic w_unused_rd;
  logic w_unused_cfg;

  assign soft_reset   = '0;
  assign w_unused_rd  = ^read_enb;
  assign w_unused_cfg = (TIMEOUT < 2);
`endif

endmodule

// File: tb/tb_router_dst_sync.sv
// Scoreboard bench for router_dst_sync: expectations from a cycle model are queued
// at drive time and compared at the following negedge.
`timescale 1ns/1ps
module tb_router_dst_sync;
  import router_pkg::*;

  localparam int unsigned TMO = 30;
`ifdef ROUTER_DST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_DST-1:0] we;
    logic               ff;
    logic [NUM_DST-1:0] vld;
    logic [NUM_DST-1:0] sr;
    logic               ae;
  } exp_t;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               detect_add = 1'b0;
  dst_addr_t          data_in = '0;
  logic               write_enb_reg = 1'b0;
  logic [NUM_DST-1:0] read_enb = '0;
  logic [NUM_DST-1:0] empty = '1;
  logic [NUM_DST-1:0] full = '0;
  logic [NUM_DST-1:0] write_enb;
  logic               fifo_full;
  logic [NUM_DST-1:0] vld_out;
  logic [NUM_DST-1:0] soft_reset;
  logic               addr_err;

  router_dst_sync #(
    .NUM_DST (NUM_DST),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TMO)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset),
    .addr_err      (addr_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  dst_addr_t          m_addr = '0;
  int                 m_cnt[NUM_DST];
  logic [NUM_DST-1:0] m_sr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out(input logic we, input logic [NUM_DST-1:0] emp,
                                     input logic [NUM_DST-1:0] fl);
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_DST; i++) begin
      if (m_addr == ADDR_W'(i)) begin
        e.we[i] = we;
        e.ff    = fl[i];
      end
    end
    e.vld = ~emp;
    e.sr  = m_sr;
    e.ae  = (m_addr == ADDR_INVALID);
    return e;
  endfunction

  task automatic model_clear();
    m_addr = '0;
    m_sr   = '0;
    for (int i = 0; i < NUM_DST; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive at negedge, pre-edge write_enb check, queue prediction, compare at next negedge
  task automatic cyc(input logic rst, input logic de, input dst_addr_t din, input logic we,
                     input logic [NUM_DST-1:0] rd, input logic [NUM_DST-1:0] emp,
                     input logic [NUM_DST-1:0] fl);
    exp_t e;
    exp_t pre;
    logic stall;
    resetn = rst; detect_add = de; data_in = din; write_enb_reg = we;
    read_enb = rd; empty = emp; full = fl;
    pre = model_out(we, emp, fl);
    #1;
    chk("we_pre_edge", 32'(write_enb), 32'(pre.we));
    if (!rst) begin
      model_clear();
    end else begin
      if (de) m_addr = din;
      for (int i = 0; i < NUM_DST; i++) begin
        stall   = !emp[i] && !rd[i];
        m_sr[i] = TMO_EN && stall && (m_cnt[i] == int'(TMO) - 1);
        m_cnt[i] = (stall && m_cnt[i] != int'(TMO) - 1) ? m_cnt[i] + 1 : 0;
      end
    end
    sb_q.push_back(model_out(we, emp, fl));
    @(negedge clock);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      chk("write_enb", 32'(write_enb), 32'(e.we));
      chk("fifo_full", 32'(fifo_full), 32'(e.ff));
      chk("vld_out", 32'(vld_out), 32'(e.vld));
      chk("soft_reset", 32'(soft_reset), 32'(e.sr));
      chk("addr_err", 32'(addr_err), 32'(e.ae));
    end
  endtask

  // Stall port 0 n times; report 1-based index of first pulse on bit 0 and pulse count
  task automatic stall0(input int n, output int first, output int count);
    first = 0;
    count = 0;
    for (int k = 1; k <= n; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, 3'b000, 3'b110, 3'b000);
      if (soft_reset[0]) begin
        count++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int count;
    int first2;
    int count2;
    model_clear();
    @(negedge clock);

    // Reset state
    cyc(1'b0, 1'b0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
    cyc(1'b0, 1'b1, 2'b10, 1'b1, 3'b000, 3'b101, 3'b001);

    // Address 1 steering and full mirroring
    cyc(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, '0, 1'b1, 3'b000, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, '0, 1'b1, 3'b000, 3'b111, 3'b101);

    // Invalid address; same-cycle detect/write uses the old address before the edge
    cyc(1'b1, 1'b1, 2'b11, 1'b1, 3'b000, 3'b111, 3'b010);
    cyc(1'b1, 1'b0, '0, 1'b1, 3'b000, 3'b111, 3'b111);
    chk("invalid_we", 32'(write_enb), 32'(0));
    chk("invalid_err", 32'(addr_err), 32'(1));

    // Addresses 2 and 0
    cyc(1'b1, 1'b1, 2'b10, 1'b1, 3'b000, 3'b011, 3'b100);
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 3'b011, 3'b100);
    cyc(1'b1, 1'b0, '0, 1'b1, 3'b000, 3'b111, 3'b001);
    idle(2);

    // Timeout on port 0
    stall0(40, first, count);
    chk("tmo_first", 32'(first), TMO_EN ? 32'(TMO) : 32'(0));
    chk("tmo_count", 32'(count), TMO_EN ? 32'(1) : 32'(0));
    idle(2);

    // Abort: read in the terminal-count cycle, then restart
    stall0(29, first, count);
    cyc(1'b1, 1'b0, '0, 1'b0, 3'b001, 3'b110, 3'b000);
    stall0(35, first2, count2);
    chk("abort_pre_pulses", 32'(count), 32'(0));
    chk("abort_first", 32'(first2), TMO_EN ? 32'(TMO) : 32'(0));
    idle(2);

    // Empty rising in the terminal-count cycle
    stall0(29, first, count);
    cyc(1'b1, 1'b0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("empty_term_pulse", 32'(soft_reset), 32'(0));
    idle(2);

    // All ports at once
    for (int k = 0; k < int'(TMO); k++) cyc(1'b1, 1'b0, '0, 1'b0, 3'b000, 3'b000, 3'b000);
    chk("simul_sr", 32'(soft_reset), TMO_EN ? 32'(3'b111) : 32'(0));

    // Asynchronous clear of a live pulse
    resetn = 1'b0;
    #1;
    chk("async_sr", 32'(soft_reset), 32'(0));
    model_clear();
    cyc(1'b0, 1'b0, '0, 1'b0, 3'b000, 3'b111, 3'b000);
    idle(2);

    // Reset mid-count at 20, then fresh count
    stall0(20, first, count);
    resetn = 1'b0;
    #1;
    chk("midrst_sr", 32'(soft_reset), 32'(0));
    model_clear();
    cyc(1'b0, 1'b0, '0, 1'b0, 3'b000, 3'b110, 3'b000);
    cyc(1'b0, 1'b0, '0, 1'b0, 3'b000, 3'b110, 3'b000);
    stall0(40, first, count);
    chk("midrst_first", 32'(first), TMO_EN ? 32'(TMO) : 32'(0));
    chk("midrst_count", 32'(count), TMO_EN ? 32'(1) : 32'(0));
    idle(2);

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
